vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 151 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer between the VGA scan-out
// and an image writer. Display reads own every fourth active cycle (the read
// slot); all other cycles are offered to the writer while an image loads.
//
// Writer handshake: a pixel moves when wr_valid and wr_ready are both high
// on a rising clk_in edge; wr_valid may be held with stable data for any
// number of cycles, and wr_ready never depends on wr_valid.
module vga_fb_arbiter #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        display_en,
    input  logic        wr_start,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        frame_done,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pix_data,
    output logic        pix_valid
);

    localparam logic [14:0] LAST_ADDR = 15'(IMG_W * IMG_H - 1);
    localparam logic [9:0]  V_BLANK   = 10'd480;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [14:0] wr_addr;
    logic        rd_slot;
    logic [14:0] rd_x;
    logic [14:0] rd_y;
    logic [14:0] rd_addr;
    logic        transfer;
    logic        last_xfer;
    logic        load_entry;

    // Scan-out pipeline: read issued at t, data returns at t+1, shown from t+2.
    logic        rd_d1;
    logic        en_d1;
    logic        en_d2;
    logic [7:0]  pix_hold;

    // Read slot and read address; the *160 is built from two shifts.
    always_comb begin
        rd_slot = display_en && (h_count[1:0] == 2'b00);
        rd_x    = 15'(h_count >> SCALE_SHIFT);
        rd_y    = 15'(v_count >> SCALE_SHIFT);
        rd_addr = (rd_y << 7) + (rd_y << 5) + rd_x;
    end

    // Next-state logic: ARM waits for vertical blanking before loading starts.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (wr_start) state_next = S_ARM;
            S_ARM:  if (v_count >= V_BLANK) state_next = S_LOAD;
            S_LOAD: if (last_xfer) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and memory port muxing; reads win the read slot outright.
    always_comb begin
        wr_ready   = 1'b0;
        transfer   = 1'b0;
        last_xfer  = 1'b0;
        load_entry = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = wr_data;
        mem_addr   = wr_addr;
        busy       = (state != S_IDLE);
        if (!reset && (state == S_LOAD) && !rd_slot) begin
            wr_ready = 1'b1;
        end
        transfer   = wr_valid && wr_ready;
        last_xfer  = transfer && (wr_addr == LAST_ADDR);
        load_entry = (state == S_ARM) && (state_next == S_LOAD);
        mem_we     = transfer;
        if (rd_slot) begin
            mem_addr = rd_addr;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write address counter; restarts at each load and after the last pixel.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_addr <= 15'd0;
        end else if (load_entry || last_xfer) begin
            wr_addr <= 15'd0;
        end else if (transfer) begin
            wr_addr <= wr_addr + 15'd1;
        end
    end

    // One-cycle completion pulse following the final accepted pixel.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_xfer;
        end
    end

    // Scan-out pipeline: capture read data one cycle after the read slot.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_d1    <= 1'b0;
            en_d1    <= 1'b0;
            en_d2    <= 1'b0;
            pix_hold <= 8'd0;
        end else begin
            rd_d1 <= rd_slot;
            en_d1 <= display_en;
            en_d2 <= en_d1;
            if (rd_d1) begin
                pix_hold <= mem_rdata;
            end
        end
    end

    // Blank the pixel output outside the delayed active area.
    always_comb begin
        pix_valid = en_d2;
        pix_data  = en_d2 ? pix_hold : 8'd0;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: framebuffer model, table-driven address vectors,
// a write scoreboard, and hand sequences for load, scan-out and reset cases.
module tb_vga_fb_arbiter;

    localparam int NPIX = 19200;
    localparam int LAST = NPIX - 1;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        display_en;
    logic        wr_start;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        frame_done;
    logic        busy;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;

    vga_fb_arbiter dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .h_count    (h_count),
        .v_count    (v_count),
        .display_en (display_en),
        .wr_start   (wr_start),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_done (frame_done),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- framebuffer model ----------------
    logic [7:0] fb [0:NPIX-1];
    logic [7:0] fb_q;
    logic       rd_force;

    always @(posedge clk_in) begin
        if (mem_we && (int'(mem_addr) < NPIX)) fb[mem_addr] <= mem_wdata;
        if (int'(mem_addr) < NPIX) fb_q <= fb[mem_addr];
        else fb_q <= 8'h00;
    end

    assign mem_rdata = rd_force ? 8'h5A : fb_q;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [22:0] exp_q[$];
    int          wr_next = 0;
    int          wr_cnt = 0;
    bit          writer_on = 0;
    bit          offered = 0;
    bit          accepted = 0;
    bit          exp_fd = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample half: compare writes against the queue and frame_done against the model.
    task automatic at_neg();
        logic [22:0] e;
        @(negedge clk_in);
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h, expected no write", mem_addr);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", int'(mem_addr), int'(e[22:8]));
                check("write_data", int'(mem_wdata), int'(e[7:0]));
            end
        end
        check("frame_done", int'(frame_done), int'(exp_fd));
        accepted = wr_valid && wr_ready;
    endtask

    // Drive half: advance the writer model and offer the next pixel.
    task automatic at_pos();
        @(posedge clk_in);
        #1;
        exp_fd = accepted && (wr_next == LAST);
        if (accepted) begin
            wr_cnt++;
            wr_next = (wr_next == LAST) ? 0 : wr_next + 1;
            offered = 0;
        end
        if (writer_on && !offered) begin
            wr_valid = 1'b1;
            wr_data  = 8'(wr_next);
            exp_q.push_back({15'(wr_next), 8'(wr_next)});
            offered  = 1;
        end else if (!offered) begin
            wr_valid = 1'b0;
        end
    endtask

    task automatic tick();
        at_neg();
        at_pos();
    endtask

    task automatic drop_offer();
        if (offered) void'(exp_q.pop_back());
        offered   = 0;
        writer_on = 0;
        wr_valid  = 1'b0;
    endtask

    task automatic start_load();
        wr_start  = 1'b1;
        wr_next   = 0;
        writer_on = 1;
        tick();
        wr_start  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        drop_offer();
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            at_neg();
            check("rst_wr_ready", int'(wr_ready), 0);
            check("rst_mem_we", int'(mem_we), 0);
            at_pos();
        end
        reset   = 1'b0;
        wr_next = 0;
        exp_fd  = 0;
    endtask

    // Scan-out probe: one read slot at (h0,v0), display_en for 4 cycles.
    task automatic pix_probe(input string name, input int h0, input int v0,
                             input bit force_rd, input int exp);
        display_en = 1'b0;
        repeat (3) tick();
        for (int k = 0; k <= 6; k++) begin
            h_count    = 10'(h0 + k);
            v_count    = 10'(v0);
            display_en = (k < 4);
            rd_force   = force_rd && (k == 1);
            at_neg();
            if (k >= 2 && k <= 5) begin
                check({name, "_valid"}, int'(pix_valid), 1);
                check({name, "_data"}, int'(pix_data), exp);
            end else begin
                check({name, "_valid_off"}, int'(pix_valid), 0);
                check({name, "_data_off"}, int'(pix_data), 0);
            end
            at_pos();
        end
        rd_force   = 1'b0;
        display_en = 1'b0;
    endtask

    // ---------------- address vector table ----------------
    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        en;
        logic [14:0] addr;
    } vec_t;

    vec_t vt[8];

    initial begin
        int  c0;
        bit  got_fd;

        vt[0] = '{h: 10'd0,   v: 10'd0,   en: 1'b1, addr: 15'd0};
        vt[1] = '{h: 10'd4,   v: 10'd0,   en: 1'b1, addr: 15'd1};
        vt[2] = '{h: 10'd644, v: 10'd8,   en: 1'b1, addr: 15'd481};
        vt[3] = '{h: 10'd636, v: 10'd476, en: 1'b1, addr: 15'd19199};
        vt[4] = '{h: 10'd12,  v: 10'd4,   en: 1'b1, addr: 15'd163};
        vt[5] = '{h: 10'd320, v: 10'd240, en: 1'b1, addr: 15'd9680};
        vt[6] = '{h: 10'd1,   v: 10'd0,   en: 1'b1, addr: 15'd0};
        vt[7] = '{h: 10'd8,   v: 10'd4,   en: 1'b0, addr: 15'd0};

        reset = 1'b1; h_count = '0; v_count = '0; display_en = 1'b0;
        wr_start = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_force = 1'b0;

        // Reset state
        do_reset(3);
        at_neg();
        check("reset_busy", int'(busy), 0);
        check("reset_wr_ready", int'(wr_ready), 0);
        check("reset_pix_valid", int'(pix_valid), 0);
        check("reset_pix_data", int'(pix_data), 0);
        check("reset_mem_we", int'(mem_we), 0);
        at_pos();

        // Address mux in IDLE: read address in read slots, wr_addr otherwise
        foreach (vt[i]) begin
            h_count = vt[i].h; v_count = vt[i].v; display_en = vt[i].en;
            at_neg();
            check("vec_mem_addr", int'(mem_addr), int'(vt[i].addr));
            check("vec_wr_ready", int'(wr_ready), 0);
            check("vec_mem_we", int'(mem_we), 0);
            at_pos();
        end

        // Read data returned at t+1 appears at t+2..t+5
        pix_probe("pix_5a", 0, 0, 1'b1, 8'h5A);

        // Arm away from blanking: no acceptance until v_count reaches 480
        h_count = 10'd700; v_count = 10'd100; display_en = 1'b0;
        c0 = wr_cnt;
        start_load();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) v_count = 10'd479;
            at_neg();
            check("arm_busy", int'(busy), 1);
            check("arm_wr_ready", int'(wr_ready), 0);
            check("arm_mem_we", int'(mem_we), 0);
            at_pos();
        end
        v_count = 10'd480;
        at_neg();
        check("arm_edge_wr_ready", int'(wr_ready), 0);
        at_pos();
        at_neg();
        check("load_wr_ready", int'(wr_ready), 1);
        check("load_first_we", int'(mem_we), 1);
        at_pos();
        repeat (20) tick();

        // Active line during load: 3 writes per 4 cycles, reads in slot 0
        begin
            int cw;
            cw = wr_cnt;
            for (int k = 0; k < 16; k++) begin
                h_count = 10'(k); v_count = 10'd8; display_en = 1'b1;
                at_neg();
                check("line_wr_ready", int'(wr_ready), int'((k % 4) != 0));
                if ((k % 4) == 0) begin
                    check("line_rd_addr", int'(mem_addr), 2 * 160 + k / 4);
                    check("line_rd_we", int'(mem_we), 0);
                end
                at_pos();
            end
            check("line_write_count", wr_cnt - cw, 12);
        end

        // A second wr_start during LOAD changes nothing
        display_en = 1'b0; v_count = 10'd480; h_count = 10'd700;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;

        // Finish the image in blanking
        got_fd = 0;
        for (int i = 0; i < 25000 && !got_fd; i++) begin
            at_neg();
            if (frame_done) got_fd = 1;
            at_pos();
        end
        if (!got_fd) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_done_timeout: no frame_done within 25000 cycles");
        end
        drop_offer();
        check("frame_write_count", wr_cnt - c0, NPIX);
        at_neg();
        check("done_busy", int'(busy), 0);
        check("done_wr_addr", int'(mem_addr), 0);
        check("done_wr_ready", int'(wr_ready), 0);
        at_pos();

        // Scan-out of the loaded image
        pix_probe("pix_644_8", 644, 8, 1'b0, (2 * 160 + 161) & 255);
        pix_probe("pix_636_476", 636, 476, 1'b0, LAST & 255);

        // Reset during load abandons the image
        v_count = 10'd480;
        c0 = wr_cnt;
        start_load();
        for (int i = 0; i < 2000 && (wr_cnt - c0) < 1000; i++) tick();
        check("pre_reset_writes", wr_cnt - c0, 1000);
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            at_neg();
            check("post_reset_busy", int'(busy), 0);
            at_pos();
        end

        // Next load restarts from address 0 (scoreboard checks the address)
        c0 = wr_cnt;
        start_load();
        repeat (12) tick();
        check("restart_writes", int'((wr_cnt - c0) > 0), 1);
        drop_offer();
        do_reset(2);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
